uart_tx_frame: RTL and testbench

- UART transmitter that pairs with the existing receive path: 8N1 framing, LSB first, idle-high line.
- Baud timing is generated internally from the system clock, using the same rate parameters as the receive-side baud generator.
- Accepts one byte per valid/ready handshake from the system side and drives the serial TX pin.
- Sits between the byte source (FIFO or controller) and the FPGA TX pad.

---
 rtl/uart_tx_frame_if.sv | 18 +
 rtl/uart_tx_frame.sv | 134 +++++++++++++
 tb/tb_uart_tx_frame.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// Byte handshake between a byte source (FIFO or controller) and the UART transmitter.
interface uart_tx_frame_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_frame.sv
// 8N1 UART transmitter: LSB first, idle-high line, internal baud timing
// derived from the system clock with the same rate parameters as the receiver.
module uart_tx_frame #(
  parameter int unsigned SYS_RATE  = 100000000,
  parameter int unsigned BAND_RATE = 9600
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_frame_if.slave  bus,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done
);

  localparam int unsigned CNT_BAND = SYS_RATE / BAND_RATE;
  localparam logic [15:0] CNT_MAX  = 16'(CNT_BAND - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic        tx_n;
  logic        ready_q, ready_n;
  logic        busy_n;
  logic        done_n;
  logic        bit_end;

  assign bus.tx_ready = ready_q;
  assign bit_end      = (cnt == CNT_MAX);

  // State and registered outputs; reset drives the line high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      ready_q <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
      ready_q <= ready_n;
      tx_busy <= busy_n;
      tx_done <= done_n;
    end
  end

  // Next-state, bit timing and next values of the registered outputs.
  // Outputs are computed one edge early so tx/ready/busy/done come straight from flops.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx;
    ready_n   = ready_q;
    busy_n    = tx_busy;
    done_n    = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.tx_valid && ready_q) begin
          shift_n = bus.tx_data;
          state_n = START;
          tx_n    = 1'b0;
          ready_n = 1'b0;
          busy_n  = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_n   = DATA;
          cnt_n     = '0;
          bit_idx_n = '0;
          tx_n      = shift[0];
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx != 3'd7) begin
            shift_n   = shift >> 1;
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shift[1];
          end else begin
            state_n = STOP;
            tx_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          cnt_n   = '0;
          ready_n = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        tx_n    = 1'b1;
        ready_n = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: a fast instance (16 clocks per bit) checked cycle by
// cycle against an ideal 8N1 waveform, and a second instance with a non-trivial
// rate division checked by a mid-bit sampling receiver.
module tb_uart_tx_frame;
  localparam int CNT1 = 16;
  localparam int CNT2 = 1000 / 37;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_frame_if bif();
  uart_tx_frame_if bif2();

  logic tx, tx_busy, tx_done;
  logic tx2, tx_busy2, tx_done2;

  uart_tx_frame #(.SYS_RATE(16), .BAND_RATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_frame #(.SYS_RATE(1000), .BAND_RATE(37)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bif2.slave),
    .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  int compared = 0;
  int mismatched = 0;

  // Ideal line level k cycles after the accept edge: start, 8 data bits LSB first, stop.
  function automatic logic exp_level(input logic [7:0] b, input int k, input int cnt);
    int slot;
    slot = k / cnt;
    if (slot == 0) return 1'b0;
    if (slot >= 9) return 1'b1;
    return b[slot - 1];
  endfunction

  // Present a byte on dut and return #1 after its accept edge with tx_valid dropped.
  task automatic start_frame(input logic [7:0] b, input logic hold_valid);
    int waited;
    waited = 0;
    @(negedge clk);
    while (bif.tx_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    compared++;
    if (bif.tx_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL start_ready: tx_ready=%b, required 1 within 50 cycles", bif.tx_ready);
    end
    bif.tx_data  = b;
    bif.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_valid) bif.tx_valid = 1'b0;
    bif.tx_data = 8'($urandom);
  endtask

  // Follow one frame from the cycle after accept; optionally pulse tx_valid with 0xFF at cycle inj.
  task automatic watch_frame(input logic [7:0] b, input string name, input int inj);
    logic e;
    for (int k = 0; k < 10 * CNT1; k++) begin
      @(negedge clk);
      if (k == inj) begin
        bif.tx_valid = 1'b1;
        bif.tx_data  = 8'hFF;
      end else if (k == inj + 1) begin
        bif.tx_valid = 1'b0;
      end
      e = exp_level(b, k, CNT1);
      compared++;
      if (tx !== e || tx_busy !== 1'b1 || bif.tx_ready !== 1'b0 || tx_done !== 1'b0) begin
        mismatched++;
        $display("FAIL %s byte=%h k=%0d: tx=%b busy=%b ready=%b done=%b, required tx=%b busy=1 ready=0 done=0",
                 name, b, k, tx, tx_busy, bif.tx_ready, tx_done, e);
      end
    end
    @(negedge clk);
    compared++;
    if (tx_done !== 1'b1 || bif.tx_ready !== 1'b1 || tx !== 1'b1 || tx_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_done byte=%h: done=%b ready=%b tx=%b busy=%b, required done=1 ready=1 tx=1 busy=0",
               name, b, tx_done, bif.tx_ready, tx, tx_busy);
    end
  endtask

  task automatic test_reset();
    bif.tx_valid  = 1'b0;
    bif.tx_data   = 8'h00;
    bif2.tx_valid = 1'b0;
    bif2.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    compared++;
    if (tx !== 1'b1 || bif.tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_held: tx=%b ready=%b busy=%b done=%b, required 1 1 0 0",
               tx, bif.tx_ready, tx_busy, tx_done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      compared++;
      if (tx !== 1'b1 || bif.tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_idle cycle %0d: tx=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                 i, tx, bif.tx_ready, tx_busy, tx_done);
      end
    end
  endtask

  task automatic test_single();
    start_frame(8'h55, 1'b0);
    watch_frame(8'h55, "single55", -10);
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom);
      start_frame(b, 1'b0);
      watch_frame(b, "random", -10);
    end
  endtask

  // tx_valid stays high; the second accept lands on the tx_done edge.
  task automatic test_back_to_back();
    start_frame(8'hA3, 1'b1);
    bif.tx_data = 8'h0F;
    watch_frame(8'hA3, "b2b_first", -10);
    @(posedge clk);
    #1;
    bif.tx_valid = 1'b0;
    bif.tx_data  = 8'hC6;
    watch_frame(8'h0F, "b2b_second", -10);
  endtask

  task automatic test_ignored();
    start_frame(8'h3C, 1'b0);
    watch_frame(8'h3C, "ignored", 50);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      compared++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || bif.tx_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL ignored_idle cycle %0d: tx=%b busy=%b ready=%b, required 1 0 1",
                 i, tx, tx_busy, bif.tx_ready);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    start_frame(8'h00, 1'b0);
    repeat (4 * CNT1 + 6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || bif.tx_ready !== 1'b1 || tx_done !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_async: tx=%b busy=%b ready=%b done=%b, required 1 0 1 0",
               tx, tx_busy, bif.tx_ready, tx_done);
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20 * CNT1; i++) begin
      @(negedge clk);
      compared++;
      if (tx_done !== 1'b0 || tx !== 1'b1 || tx_busy !== 1'b0) begin
        mismatched++;
        $display("FAIL abort_after cycle %0d: done=%b tx=%b busy=%b, required 0 1 0",
                 i, tx_done, tx, tx_busy);
      end
    end
    start_frame(8'h81, 1'b0);
    watch_frame(8'h81, "after_abort", -10);
  endtask

  // Mid-bit sampling receiver on the second instance.
  task automatic test_other_rate();
    logic [7:0] b, rx;
    int done_k, slot;
    for (int n = 0; n < 3; n++) begin
      b = 8'($urandom);
      rx = '0;
      done_k = -1;
      @(negedge clk);
      bif2.tx_data  = b;
      bif2.tx_valid = 1'b1;
      @(posedge clk);
      #1;
      bif2.tx_valid = 1'b0;
      for (int k = 0; k < 10 * CNT2 + 5; k++) begin
        @(negedge clk);
        if (k % CNT2 == CNT2 / 2 && k < 10 * CNT2) begin
          slot = k / CNT2;
          if (slot == 0 || slot == 9) begin
            compared++;
            if (tx2 !== (slot == 9)) begin
              mismatched++;
              $display("FAIL rate2_framing byte=%h slot=%0d: tx=%b, required %b", b, slot, tx2, slot == 9);
            end
          end else begin
            rx[slot - 1] = tx2;
          end
        end
        if (tx_done2 === 1'b1 && done_k < 0) done_k = k;
      end
      compared++;
      if (rx !== b) begin
        mismatched++;
        $display("FAIL rate2_data: received %h, required %h", rx, b);
      end
      compared++;
      if (done_k != 10 * CNT2) begin
        mismatched++;
        $display("FAIL rate2_length: done at cycle %0d, required %0d", done_k, 10 * CNT2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_ignored();
    test_reset_mid_frame();
    test_other_rate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
